present_enc_ctrl: RTL and testbench
===================================

// Module: present_enc_ctrl
// PURPOSE
//  Sequencer for the PRESENT-80 encryption core. Takes a key and plaintext
//  blocks over valid/ready handshakes and drives the core's shared 80-bit load bus.
//  Before every block it reloads the key, because the core destroys its key register
//  during rounds. It then runs 31 rounds, captures the ciphertext and holds it until
//  the ciphertext is accepted. It sits beside present_encryptor_top inside present_enc_subsys.
// PARAMETERS
//  KEY_W       80  key width; core load bus width
//  BLK_W       64  block width
//  NUM_ROUNDS  31  SP-round cycles between data load and final key add
// PORTS
//  clk_i            in   1      clock; all logic on posedge
//  rst_ni           in   1      synchronous active-low reset
//  key_i            in   80     key to store
//  key_valid_i      in   1      key offered
//  key_ready_o      out  1      key accepted when valid&ready
//  pt_i             in   64     plaintext block
//  pt_valid_i       in   1      plaintext offered
//  pt_ready_o       out  1      plaintext accepted when valid&ready
//  ct_o             out  64     ciphertext (registered)
//  ct_valid_o       out  1      ct_o valid
//  ct_ready_i       in   1      consumer takes ct_o
//  busy_o           out  1      FSM not in IDLE
//  core_data_o      out  80     to core data_i
//  core_key_load_o  out  1      to core key_load
//  core_data_load_o out  1      to core data_load
//  core_data_i      in   64     from core data_o
// BEHAVIOUR
//  Reset (rst_ni=0 at posedge, also mid-operation):
//   - FSM goes to IDLE; key_loaded_q=0; rnd_cnt=0; ct_o=0; all handshake/strobe outputs 0.
//   - The core has no reset; its contents are don't-care until the next load.
//  FSM states: IDLE, LOAD_KEY, LOAD_DATA, RUN, FINAL, DONE.
//  - IDLE:
//    - key_ready_o=1; pt_ready_o=key_loaded_q.
//    - Key handshake: key_q<=key_i, key_loaded_q<=1.
//    - Pt handshake: pt_q<=pt_i, go to LOAD_KEY.
//    - Both handshakes in the same cycle: both are accepted and the block uses the new key.
//  - LOAD_KEY (1 cycle): core_key_load_o=1, core_data_o=key_q -> LOAD_DATA.
//  - LOAD_DATA (1 cycle): core_data_load_o=1, core_data_o={16'h0,pt_q}; rnd_cnt<=1 -> RUN.
//  - RUN: both strobes 0; core advances one round per cycle; rnd_cnt++.
//    - When rnd_cnt==NUM_ROUNDS, go to FINAL (31 RUN cycles in total).
//  - FINAL (1 cycle): ct_q<=core_data_i (state^K32) -> DONE.
//  - DONE: ct_valid_o=1; ct_o stable. On ct_ready_i, go to IDLE.
//  Strobe and bus rules:
//   - The two core strobes are never high together.
//   - core_data_o=0 when no strobe is high.
//   - key_ready_o and pt_ready_o are 0 outside IDLE.
//  Latency: pt handshake at cycle T -> ct_valid_o=1 at T+35 (T+35 if ct_ready_i is already high).
//   Throughput is 1 block per 36 cycles. Back-to-back: pt_ready_o returns in the cycle after DONE exits.
//  Held key: key_q persists across blocks; key updates are only possible in IDLE.
//  Free-running core: in IDLE and DONE the core keeps iterating.
//   This is harmless because every block reloads both key and state.
//  Widths: rnd_cnt is 5 bits; it saturates at NUM_ROUNDS and is never compared after wrap.
//  ct_ready_i outside DONE is ignored. pt_valid_i with key_loaded_q=0 is stalled, not dropped.
// STRUCTURE
//  present_pkg:
//   - localparams KEY_W, BLK_W, NUM_ROUNDS.
//   - typedef enum logic[2:0] ctrl_state_e {IDLE,LOAD_KEY,LOAD_DATA,RUN,FINAL,DONE}.
//  Single module, one registered FSM plus key/pt/ct/rnd_cnt registers.
//  No sub-module. present_encryptor_top is instantiated next to it in present_enc_subsys.
// TESTING (via present_enc_subsys)
//  1 key=0, pt=0 -> ct_o=64'h5579C1387B228445, ct_valid_o exactly 35 cycles after pt handshake.
//  2 key=80'hFFFF_FFFF_FFFF_FFFF_FFFF, pt=0 -> 64'hE72C46C0F5945049.
//    Then, with no key reload, pt=64'hFFFF_FFFF_FFFF_FFFF -> 64'h3333DCD3213210D2 (held key reused).
//  3 pt_valid_i high before any key -> pt_ready_o=0, busy_o=0.
//    Then key=0 offered in the same cycle as pt=64'hFFFF_FFFF_FFFF_FFFF -> 64'hA112FFC72F68417B.
//  4 ct_ready_i held low 10 cycles in DONE -> ct_o/ct_valid_o stable; pt_ready_o=0; key_ready_o=0.
//  5 rst_ni=0 during RUN (rnd_cnt=12) -> next cycle: IDLE, all outputs 0, key_loaded_q=0.
//    Then reload key=0, pt=0 -> 64'h5579C1387B228445.
//  6 Assertions: never both core strobes high; core_data_o==0 without a strobe; ct_o stable while ct_valid_o&!ct_ready_i.

Source files
------------

// File: rtl/present_pkg.sv
// Shared widths and FSM state type for the PRESENT-80 encryption sequencer.
package present_pkg;

    localparam int unsigned KEY_W      = 80;
    localparam int unsigned BLK_W      = 64;
    localparam int unsigned NUM_ROUNDS = 31;
    localparam int unsigned RND_W      = 5;

    typedef enum logic [2:0] {
        StIdle,
        StLoadKey,
        StLoadData,
        StRun,
        StFinal,
        StDone
    } ctrl_state_e;

endpackage

// File: rtl/present_enc_ctrl.sv
// Sequencer for the PRESENT-80 core: reloads key and block every time, counts the rounds,
// then captures and holds the ciphertext until the consumer accepts it.
module present_enc_ctrl
    import present_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [KEY_W-1:0]   key_i,
    input  logic               key_valid_i,
    output logic               key_ready_o,
    input  logic [BLK_W-1:0]   pt_i,
    input  logic               pt_valid_i,
    output logic               pt_ready_o,
    output logic [BLK_W-1:0]   ct_o,
    output logic               ct_valid_o,
    input  logic               ct_ready_i,
    output logic               busy_o,
    output logic [KEY_W-1:0]   core_data_o,
    output logic               core_key_load_o,
    output logic               core_data_load_o,
    input  logic [BLK_W-1:0]   core_data_i
);

    ctrl_state_e      state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [BLK_W-1:0] pt_q, pt_d;
    logic [BLK_W-1:0] ct_q, ct_d;
    logic             key_loaded_q, key_loaded_d;
    logic [RND_W-1:0] rnd_cnt_q, rnd_cnt_d;

    logic             key_ready_q, key_ready_d;
    logic             pt_ready_q, pt_ready_d;
    logic             ct_valid_q, ct_valid_d;
    logic             busy_q, busy_d;
    logic             key_load_q, key_load_d;
    logic             data_load_q, data_load_d;
    logic [KEY_W-1:0] core_data_q, core_data_d;

    logic key_hs, pt_hs;

    // Ready flags are registered, so they are only ever high while state_q is StIdle.
    assign key_hs = key_valid_i & key_ready_q;
    assign pt_hs  = pt_valid_i & pt_ready_q;

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        pt_d         = pt_q;
        ct_d         = ct_q;
        key_loaded_d = key_loaded_q;
        rnd_cnt_d    = rnd_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (key_hs) begin
                    key_d        = key_i;
                    key_loaded_d = 1'b1;
                end
                if (pt_hs) begin
                    pt_d    = pt_i;
                    state_d = StLoadKey;
                end
            end
            StLoadKey:  state_d = StLoadData;
            StLoadData: begin
                rnd_cnt_d = RND_W'(1);
                state_d   = StRun;
            end
            StRun: begin
                if (rnd_cnt_q == RND_W'(NUM_ROUNDS)) begin
                    state_d = StFinal;
                end else begin
                    rnd_cnt_d = rnd_cnt_q + RND_W'(1);
                end
            end
            StFinal: begin
                ct_d    = core_data_i;
                state_d = StDone;
            end
            StDone: begin
                if (ct_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so they register in step with state_q.
        key_ready_d = (state_d == StIdle);
        pt_ready_d  = (state_d == StIdle) && key_loaded_d;
        ct_valid_d  = (state_d == StDone);
        busy_d      = (state_d != StIdle);
        key_load_d  = (state_d == StLoadKey);
        data_load_d = (state_d == StLoadData);
        if (state_d == StLoadKey) begin
            core_data_d = key_d;
        end else if (state_d == StLoadData) begin
            core_data_d = {{(KEY_W - BLK_W){1'b0}}, pt_d};
        end else begin
            core_data_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            key_q        <= '0;
            pt_q         <= '0;
            ct_q         <= '0;
            key_loaded_q <= 1'b0;
            rnd_cnt_q    <= '0;
            key_ready_q  <= 1'b0;
            pt_ready_q   <= 1'b0;
            ct_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            key_load_q   <= 1'b0;
            data_load_q  <= 1'b0;
            core_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            pt_q         <= pt_d;
            ct_q         <= ct_d;
            key_loaded_q <= key_loaded_d;
            rnd_cnt_q    <= rnd_cnt_d;
            key_ready_q  <= key_ready_d;
            pt_ready_q   <= pt_ready_d;
            ct_valid_q   <= ct_valid_d;
            busy_q       <= busy_d;
            key_load_q   <= key_load_d;
            data_load_q  <= data_load_d;
            core_data_q  <= core_data_d;
        end
    end

    assign key_ready_o      = key_ready_q;
    assign pt_ready_o       = pt_ready_q;
    assign ct_o             = ct_q;
    assign ct_valid_o       = ct_valid_q;
    assign busy_o           = busy_q;
    assign core_data_o      = core_data_q;
    assign core_key_load_o  = key_load_q;
    assign core_data_load_o = data_load_q;

endmodule

// File: tb/tb_present_enc_ctrl.sv
// Directed bench: the sequencer drives a behavioural PRESENT-80 round core, checked
// against published known-answer vectors plus handshake, latency and reset behaviour.
module tb_present_enc_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [79:0] key_i;
    logic        key_valid_i;
    logic        key_ready_o;
    logic [63:0] pt_i;
    logic        pt_valid_i;
    logic        pt_ready_o;
    logic [63:0] ct_o;
    logic        ct_valid_o;
    logic        ct_ready_i;
    logic        busy_o;
    logic [79:0] core_data_o;
    logic        core_key_load_o;
    logic        core_data_load_o;
    logic [63:0] core_data_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    present_enc_ctrl dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .key_i           (key_i),
        .key_valid_i     (key_valid_i),
        .key_ready_o     (key_ready_o),
        .pt_i            (pt_i),
        .pt_valid_i      (pt_valid_i),
        .pt_ready_o      (pt_ready_o),
        .ct_o            (ct_o),
        .ct_valid_o      (ct_valid_o),
        .ct_ready_i      (ct_ready_i),
        .busy_o          (busy_o),
        .core_data_o     (core_data_o),
        .core_key_load_o (core_key_load_o),
        .core_data_load_o(core_data_load_o),
        .core_data_i     (core_data_i)
    );

    // Behavioural PRESENT-80 core: key_load sets key, data_load sets state, otherwise one round.
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [63:0] t;
        t = 64'h21748FE3DA09B65C;
        return t[x*4 +: 4];
    endfunction

    function automatic logic [63:0] round_fn(input logic [63:0] x);
        logic [63:0] s, p;
        for (int i = 0; i < 16; i++) s[i*4 +: 4] = sbox(x[i*4 +: 4]);
        for (int i = 0; i < 63; i++) p[(i*16) % 63] = s[i];
        p[63] = s[63];
        return p;
    endfunction

    function automatic logic [79:0] key_upd(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] t;
        t = {k[18:0], k[79:19]};
        t[79:76] = sbox(t[79:76]);
        t[19:15] = t[19:15] ^ rc;
        return t;
    endfunction

    logic [79:0] m_key;
    logic [63:0] m_state;
    logic [4:0]  m_rc;

    always @(posedge clk) begin
        if (core_key_load_o) begin
            m_key <= core_data_o;
            m_rc  <= 5'd1;
        end else if (core_data_load_o) begin
            m_state <= core_data_o[63:0];
        end else begin
            m_state <= round_fn(m_state ^ m_key[79:16]);
            m_key   <= key_upd(m_key, m_rc);
            m_rc    <= m_rc + 5'd1;
        end
    end

    assign core_data_i = m_state ^ m_key[79:16];

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Continuous bus rules, sampled mid-cycle.
    logic        prev_hold = 1'b0;
    logic [63:0] prev_ct   = '0;
    always @(negedge clk) begin
        if (rst_ni === 1'b1) begin
            checks++;
            assert (!(core_key_load_o && core_data_load_o)) else begin
                failures++;
                $error("FAIL strobe_excl observed=%b%b expected=not both",
                       core_key_load_o, core_data_load_o);
            end
            checks++;
            assert (core_key_load_o || core_data_load_o || core_data_o === '0) else begin
                failures++;
                $error("FAIL idle_bus observed=%h expected=0", core_data_o);
            end
            if (prev_hold && ct_valid_o) begin
                checks++;
                assert (ct_o === prev_ct) else begin
                    failures++;
                    $error("FAIL ct_stable observed=%h expected=%h", ct_o, prev_ct);
                end
            end
        end
        prev_hold <= ct_valid_o && !ct_ready_i;
        prev_ct   <= ct_o;
    end

    // Holds pt_valid_i until accepted; a key offered alongside is dropped once taken.
    task automatic wait_pt_hs(input string tag);
        logic hs;
        logic kacc;
        int   n;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 50) begin
            hs   = pt_valid_i && pt_ready_o;
            kacc = key_valid_i && key_ready_o;
            @(posedge clk); #1;
            n++;
            if (kacc) key_valid_i = 1'b0;
        end
        pt_valid_i = 1'b0;
        key_valid_i = 1'b0;
        if (!hs) check({tag, "_pt_hs"}, 80'd0, 80'd1);
    endtask

    task automatic run_block(input logic kv, input logic [79:0] k, input logic [63:0] p,
                             input logic [63:0] exp, input string tag);
        int lat;
        key_valid_i = kv;
        key_i       = k;
        pt_valid_i  = 1'b1;
        pt_i        = p;
        wait_pt_hs(tag);
        lat = 1;
        while (!ct_valid_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 80'(lat), 80'd35);
        check({tag, "_ct"}, 80'(ct_o), 80'(exp));
    endtask

    task automatic exit_done(input string tag);
        ct_ready_i = 1'b1;
        @(posedge clk); #1;
        check({tag, "_exit_valid"}, 80'(ct_valid_o), 80'd0);
        check({tag, "_exit_busy"}, 80'(busy_o), 80'd0);
        check({tag, "_exit_pt_ready"}, 80'(pt_ready_o), 80'd1);
    endtask

    initial begin
        rst_ni      = 1'b0;
        key_i       = '0;
        key_valid_i = 1'b0;
        pt_i        = '0;
        pt_valid_i  = 1'b0;
        ct_ready_i  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ct", 80'(ct_o), 80'd0);
        check("rst_ct_valid", 80'(ct_valid_o), 80'd0);
        check("rst_busy", 80'(busy_o), 80'd0);
        check("rst_key_ready", 80'(key_ready_o), 80'd0);
        check("rst_pt_ready", 80'(pt_ready_o), 80'd0);
        rst_ni = 1'b1;
        @(posedge clk); #1;
        check("idle_key_ready", 80'(key_ready_o), 80'd1);
        check("idle_pt_ready", 80'(pt_ready_o), 80'd0);

        // Plaintext before any key is stalled.
        pt_valid_i = 1'b1;
        pt_i       = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (3) begin
            @(posedge clk); #1;
            check("nokey_pt_ready", 80'(pt_ready_o), 80'd0);
            check("nokey_busy", 80'(busy_o), 80'd0);
        end
        run_block(1'b1, 80'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hA112FFC72F68417B, "k0_ptF");
        exit_done("k0_ptF");

        run_block(1'b0, 80'h0, 64'h0, 64'h5579C1387B228445, "k0_pt0");
        exit_done("k0_pt0");

        // New key and plaintext in the same cycle: block must use the new key.
        run_block(1'b1, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 64'h0, 64'hE72C46C0F5945049, "kF_pt0");
        exit_done("kF_pt0");

        // Held key reused; consumer stalls in DONE.
        ct_ready_i = 1'b0;
        run_block(1'b0, 80'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3333DCD3213210D2, "kF_ptF");
        repeat (10) begin
            @(posedge clk); #1;
            check("hold_ct", 80'(ct_o), 80'h3333DCD3213210D2);
            check("hold_valid", 80'(ct_valid_o), 80'd1);
            check("hold_pt_ready", 80'(pt_ready_o), 80'd0);
            check("hold_key_ready", 80'(key_ready_o), 80'd0);
        end
        exit_done("kF_ptF");

        // Reset in the middle of RUN clears everything including the loaded-key flag.
        pt_valid_i = 1'b1;
        pt_i       = 64'h0;
        wait_pt_hs("mid_rst");
        repeat (13) @(posedge clk);
        #1;
        check("mid_busy", 80'(busy_o), 80'd1);
        rst_ni = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        check("mid_rst_busy", 80'(busy_o), 80'd0);
        check("mid_rst_ct", 80'(ct_o), 80'd0);
        check("mid_rst_ct_valid", 80'(ct_valid_o), 80'd0);
        check("mid_rst_key_ready", 80'(key_ready_o), 80'd0);
        check("mid_rst_pt_ready", 80'(pt_ready_o), 80'd0);
        check("mid_rst_strobes", 80'({core_key_load_o, core_data_load_o}), 80'd0);
        check("mid_rst_bus", core_data_o, 80'd0);
        pt_valid_i = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("mid_rst_nokey", 80'(pt_ready_o), 80'd0);
        end
        run_block(1'b1, 80'h0, 64'h0, 64'h5579C1387B228445, "after_rst");
        exit_done("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
